commit_trace_buffer: RTL and testbench

- Synthesizable successor to the bench-only commit tracer: observes the processor's per-cycle commit signals (PC, instruction, register write, memory access, halt), classifies each committed instruction, and stamps it with an instruction number and a cycle number.
- Buffers the resulting trace records in a parametrised FIFO drained by a valid/ready port. Firmware or a host bench reads the trace without hierarchical probing.
- Adds a commit-valid qualifier for pipelined cores, overflow accounting, and a halt drain sequence.

---
 rtl/commit_trace_buffer.sv | 160 ++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - commit classifier/stamper feeding a first-word-fall-through trace FIFO
// Halt capture moves to DRAIN; done rises once the FIFO has emptied.
module commit_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmt_valid,
  input  logic [DATA_W-1:0] cmt_pc,
  input  logic [DATA_W-1:0] cmt_inst,
  input  logic              cmt_reg_write,
  input  logic [REG_W-1:0]  cmt_write_reg,
  input  logic [DATA_W-1:0] cmt_write_data,
  input  logic              cmt_mem_read,
  input  logic              cmt_mem_write,
  input  logic [DATA_W-1:0] cmt_mem_addr,
  input  logic [DATA_W-1:0] cmt_mem_data,
  input  logic              cmt_halt,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [2:0]        rec_kind,
  output logic [CNT_W-1:0]  rec_inum,
  output logic [CNT_W-1:0]  rec_cycle,
  output logic [DATA_W-1:0] rec_pc,
  output logic [DATA_W-1:0] rec_inst,
  output logic [DATA_W-1:0] rec_data,
  output logic [DATA_W-1:0] rec_addr,
  output logic [DATA_W-1:0] rec_mdata,
  output logic [REG_W-1:0]  rec_reg,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              halted,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CTR_ONE   = CNT_W'(1);
  localparam logic [2:0]       KIND_HALT = 3'd5;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} stateE;

  typedef struct packed {
    logic [2:0]        kind;
    logic [CNT_W-1:0]  inum;
    logic [CNT_W-1:0]  cycle;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
    logic [REG_W-1:0]  regIdx;
  } recordT;

  stateE            state, stateNext;
  recordT           mem [DEPTH];
  recordT           newRec, headRec;
  logic [2:0]       kind;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   fifoCount, fifoCountNext;
  logic             capture, full, push, pop, drop;

  always_comb begin
    kind = 3'd0;
    if (cmt_halt)                          kind = KIND_HALT;
    else if (cmt_reg_write && cmt_mem_write) kind = 3'd4;
    else if (cmt_mem_write)                kind = 3'd3;
    else if (cmt_reg_write && cmt_mem_read)  kind = 3'd2;
    else if (cmt_reg_write)                kind = 3'd1;
  end

  // Fields irrelevant to the commit are zeroed so records compare cleanly.
  always_comb begin
    newRec        = '0;
    newRec.kind   = kind;
    newRec.inum   = inst_count;
    newRec.cycle  = cycle_count;
    newRec.pc     = cmt_pc;
    newRec.inst   = cmt_inst;
    newRec.data   = cmt_reg_write ? cmt_write_data : '0;
    newRec.regIdx = cmt_reg_write ? cmt_write_reg : '0;
    newRec.addr   = (cmt_mem_read || cmt_mem_write) ? cmt_mem_addr : '0;
    newRec.mdata  = cmt_mem_write ? cmt_mem_data : '0;
  end

  assign rec_valid = (fifoCount != '0);
  assign full      = (fifoCount == FULL_CNT);
  assign capture   = cmt_valid && (state == RUN);
  assign pop       = rec_valid && rec_ready;
  assign push      = capture && (!full || pop);
  assign drop      = capture && full && !pop;

  always_comb begin
    fifoCountNext = fifoCount;
    if (push && !pop)      fifoCountNext = fifoCount + CNT_ONE;
    else if (pop && !push) fifoCountNext = fifoCount - CNT_ONE;
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (capture && (kind == KIND_HALT)) stateNext = DRAIN;
      DRAIN:   if (fifoCountNext == '0) stateNext = DONE;
      default: stateNext = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      state     <= stateNext;
      fifoCount <= fifoCountNext;
      if (cycle_count != '1) cycle_count <= cycle_count + CTR_ONE;
      if (push) begin
        wrPtr      <= wrPtr + PTR_ONE;
        inst_count <= inst_count + CTR_ONE;
      end
      if (pop) rdPtr <= rdPtr + PTR_ONE;
      if (drop) begin
        drop_count <= drop_count + CTR_ONE;
        overflow   <= 1'b1;
      end
    end
  end

  // Storage needs no reset: fifoCount gates everything visible.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= newRec;
  end

  assign headRec   = rec_valid ? mem[rdPtr] : '0;
  assign rec_kind  = headRec.kind;
  assign rec_inum  = headRec.inum;
  assign rec_cycle = headRec.cycle;
  assign rec_pc    = headRec.pc;
  assign rec_inst  = headRec.inst;
  assign rec_data  = headRec.data;
  assign rec_addr  = headRec.addr;
  assign rec_mdata = headRec.mdata;
  assign rec_reg   = headRec.regIdx;

  assign halted = (state != RUN);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - directed vector table plus overflow, halt and reset sequences
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk, rst;
  logic        cmt_valid, cmt_reg_write, cmt_mem_read, cmt_mem_write, cmt_halt;
  logic [15:0] cmt_pc, cmt_inst, cmt_write_data, cmt_mem_addr, cmt_mem_data;
  logic [2:0]  cmt_write_reg;
  logic        rec_valid, rec_ready;
  logic [2:0]  rec_kind;
  logic [31:0] rec_inum, rec_cycle;
  logic [15:0] rec_pc, rec_inst, rec_data, rec_addr, rec_mdata;
  logic [2:0]  rec_reg;
  logic [31:0] inst_count, cycle_count, drop_count;
  logic        overflow, halted, done;

  int errors, checks;

  commit_trace_buffer #(.DATA_W(16), .REG_W(3), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
    .cmt_reg_write(cmt_reg_write), .cmt_write_reg(cmt_write_reg), .cmt_write_data(cmt_write_data),
    .cmt_mem_read(cmt_mem_read), .cmt_mem_write(cmt_mem_write),
    .cmt_mem_addr(cmt_mem_addr), .cmt_mem_data(cmt_mem_data), .cmt_halt(cmt_halt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_inum(rec_inum), .rec_cycle(rec_cycle), .rec_pc(rec_pc), .rec_inst(rec_inst),
    .rec_data(rec_data), .rec_addr(rec_addr), .rec_mdata(rec_mdata), .rec_reg(rec_reg),
    .inst_count(inst_count), .cycle_count(cycle_count), .drop_count(drop_count),
    .overflow(overflow), .halted(halted), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        regWrite, memRead, memWrite;
    logic [15:0] pc, writeData, memAddr, memData;
    logic [2:0]  writeReg;
    logic [2:0]  expKind;
    logic [15:0] expData, expAddr, expMdata;
    logic [2:0]  expReg;
  } vecT;

  vecT vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    cmt_valid = 0; cmt_reg_write = 0; cmt_mem_read = 0; cmt_mem_write = 0; cmt_halt = 0;
    cmt_pc = 0; cmt_inst = 0; cmt_write_data = 0; cmt_mem_addr = 0; cmt_mem_data = 0;
    cmt_write_reg = 0;
  endtask

  task automatic applyVec(input vecT v);
    idle();
    cmt_valid = 1;
    cmt_reg_write = v.regWrite; cmt_mem_read = v.memRead; cmt_mem_write = v.memWrite;
    cmt_pc = v.pc; cmt_inst = v.pc ^ 16'hA500; cmt_write_data = v.writeData;
    cmt_mem_addr = v.memAddr; cmt_mem_data = v.memData; cmt_write_reg = v.writeReg;
  endtask

  task automatic regCommit(input logic [15:0] pc, input logic [15:0] data, input logic [2:0] r);
    idle();
    cmt_valid = 1; cmt_reg_write = 1; cmt_pc = pc; cmt_inst = pc ^ 16'hA500;
    cmt_write_data = data; cmt_write_reg = r;
    cmt_mem_addr = 16'hDEAD;
  endtask

  task automatic haltCommit(input logic [15:0] pc);
    idle();
    cmt_valid = 1; cmt_halt = 1; cmt_pc = pc; cmt_inst = 16'h7FFF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1; idle(); rec_ready = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    errors = 0; checks = 0;
    vecs[0] = '{1, 0, 0, 16'h0000, 16'h0011, 16'h0A00, 16'h0B00, 3'd1, 3'd1, 16'h0011, 16'h0000, 16'h0000, 3'd1};
    vecs[1] = '{1, 0, 0, 16'h0002, 16'h0022, 16'h0A02, 16'h0B02, 3'd2, 3'd1, 16'h0022, 16'h0000, 16'h0000, 3'd2};
    vecs[2] = '{1, 0, 0, 16'h0004, 16'h0033, 16'h0000, 16'h0000, 3'd3, 3'd1, 16'h0033, 16'h0000, 16'h0000, 3'd3};
    vecs[3] = '{1, 1, 0, 16'h0006, 16'h4444, 16'h0100, 16'h5555, 3'd4, 3'd2, 16'h4444, 16'h0100, 16'h0000, 3'd4};
    vecs[4] = '{0, 0, 1, 16'h0008, 16'h7777, 16'h0200, 16'hBEEF, 3'd5, 3'd3, 16'h0000, 16'h0200, 16'hBEEF, 3'd0};
    vecs[5] = '{1, 0, 1, 16'h000A, 16'h0066, 16'h0300, 16'h1234, 3'd6, 3'd4, 16'h0066, 16'h0300, 16'h1234, 3'd6};
    vecs[6] = '{0, 0, 0, 16'h000C, 16'h0999, 16'h0400, 16'h0888, 3'd7, 3'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0};

    rst = 1; rec_ready = 0; idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rec_valid", rec_valid, 0);
    check("rst_inst_count", inst_count, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_halted", halted, 0);
    check("rst_done", done, 0);
    check("rst_rec_pc", rec_pc, 0);
    check("rst_rec_inum", rec_inum, 0);

    rst = 0; rec_ready = 1;
    for (int i = 0; i < 7; i++) begin
      applyVec(vecs[i]);
      tick();
      check($sformatf("valid[%0d]", i), rec_valid, 1);
      check($sformatf("kind[%0d]", i), rec_kind, vecs[i].expKind);
      check($sformatf("inum[%0d]", i), rec_inum, i);
      check($sformatf("cycle[%0d]", i), rec_cycle, i);
      check($sformatf("pc[%0d]", i), rec_pc, vecs[i].pc);
      check($sformatf("inst[%0d]", i), rec_inst, vecs[i].pc ^ 16'hA500);
      check($sformatf("data[%0d]", i), rec_data, vecs[i].expData);
      check($sformatf("addr[%0d]", i), rec_addr, vecs[i].expAddr);
      check($sformatf("mdata[%0d]", i), rec_mdata, vecs[i].expMdata);
      check($sformatf("reg[%0d]", i), rec_reg, vecs[i].expReg);
    end
    idle();
    tick();
    check("tbl_empty_valid", rec_valid, 0);
    check("tbl_empty_data", rec_data, 0);
    check("tbl_inst_count", inst_count, 7);
    check("tbl_cycle_count", cycle_count, 8);

    // Overflow: DEPTH+2 commits into a stalled FIFO.
    doReset();
    for (int k = 0; k < DEPTH + 2; k++) begin
      regCommit(16'(2 * k), 16'(k), 3'(k));
      tick();
    end
    idle();
    check("ovf_inst_count", inst_count, DEPTH);
    check("ovf_drop_count", drop_count, 2);
    check("ovf_overflow", overflow, 1);
    check("ovf_rec_valid", rec_valid, 1);
    rec_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("ovf_valid[%0d]", k), rec_valid, 1);
      check($sformatf("ovf_inum[%0d]", k), rec_inum, k);
      check($sformatf("ovf_pc[%0d]", k), rec_pc, 2 * k);
      check($sformatf("ovf_cycle[%0d]", k), rec_cycle, k);
      tick();
    end
    check("ovf_drained", rec_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous push and pop.
    rec_ready = 0;
    for (int k = 0; k < DEPTH; k++) begin
      regCommit(16'h1000 + 16'(2 * k), 16'(k), 3'd1);
      tick();
    end
    rec_ready = 1;
    regCommit(16'h2000, 16'h00AA, 3'd2);
    tick();
    idle();
    check("pp_drop_count", drop_count, 2);
    check("pp_inst_count", inst_count, 2 * DEPTH + 1);
    for (int k = 1; k <= DEPTH; k++) begin
      check($sformatf("pp_valid[%0d]", k), rec_valid, 1);
      check($sformatf("pp_inum[%0d]", k), rec_inum, DEPTH + k);
      check($sformatf("pp_pc[%0d]", k), rec_pc, (k < DEPTH) ? 32'h1000 + 2 * k : 32'h2000);
      tick();
    end
    check("pp_drained", rec_valid, 0);

    // Halt with two records pending, then ignored commits.
    doReset();
    regCommit(16'h000C, 16'h0001, 3'd1); tick();
    regCommit(16'h000E, 16'h0002, 3'd2); tick();
    haltCommit(16'h0010); tick();
    check("halt_halted", halted, 1);
    check("halt_done_early", done, 0);
    check("halt_inst_count", inst_count, 3);
    for (int k = 0; k < 3; k++) begin
      regCommit(16'h0012, 16'h0003, 3'd3);
      tick();
    end
    idle();
    check("halt_ignored_inst", inst_count, 3);
    check("halt_ignored_drop", drop_count, 0);
    rec_ready = 1;
    check("halt_r0_pc", rec_pc, 16'h000C);
    check("halt_r0_kind", rec_kind, 1);
    tick();
    check("halt_r1_pc", rec_pc, 16'h000E);
    tick();
    check("halt_r2_pc", rec_pc, 16'h0010);
    check("halt_r2_kind", rec_kind, 5);
    check("halt_r2_inum", rec_inum, 2);
    check("halt_r2_data", rec_data, 0);
    check("halt_done_pending", done, 0);
    tick();
    check("halt_done", done, 1);
    check("halt_empty", rec_valid, 0);
    check("halt_still_halted", halted, 1);
    regCommit(16'h0040, 16'h0004, 3'd4);
    tick(); tick();
    idle();
    check("done_sticky", done, 1);
    check("done_ignored_inst", inst_count, 3);
    check("done_ignored_valid", rec_valid, 0);

    // Reset while draining with four records pending.
    doReset();
    regCommit(16'h0020, 16'h0001, 3'd1); tick();
    regCommit(16'h0022, 16'h0002, 3'd2); tick();
    regCommit(16'h0024, 16'h0003, 3'd3); tick();
    haltCommit(16'h0026); tick();
    idle();
    check("drain_halted", halted, 1);
    check("drain_valid", rec_valid, 1);
    rst = 1;
    tick();
    check("mid_rst_valid", rec_valid, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_inst", inst_count, 0);
    check("mid_rst_cycle", cycle_count, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_overflow", overflow, 0);
    rst = 0; rec_ready = 1;
    regCommit(16'h0030, 16'h005A, 3'd2);
    tick();
    idle();
    check("post_rst_valid", rec_valid, 1);
    check("post_rst_inum", rec_inum, 0);
    check("post_rst_cycle", rec_cycle, 0);
    check("post_rst_pc", rec_pc, 16'h0030);
    check("post_rst_data", rec_data, 16'h005A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
